// File: rtl/dn_benes_cfg_ctrl_if.sv
// Handshake bundle between a configuration/data source and the Benes
// configuration controller: the config word stream and the data-beat gate.
interface dn_benes_cfg_ctrl_if #(
  parameter int CFG_W = 64
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CFG_W-1:0] cfg_data;
  logic             cfg_last;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output cfg_valid, cfg_data, cfg_last, in_valid,
    input  cfg_ready, in_ready
  );

  modport slave (
    input  cfg_valid, cfg_data, cfg_last, in_valid,
    output cfg_ready, in_ready
  );
endinterface

// File: rtl/dn_benes_cfg_ctrl.sv
// Configuration and sequencing controller for the Benes distribution network.
// Config words fill a shadow bank; a complete shadow is copied to the active
// bank (with a one-cycle set_en) only once no data beats are in flight.
// Output-valid timing is rebuilt from the fixed network latency.
module dn_benes_cfg_ctrl #(
  parameter int N        = 64,
  parameter int N_LEVELS = 2*$clog2(N)-1,
  parameter int NET_LAT  = N_LEVELS,
  parameter int CFG_W    = N
) (
  input  logic                      clk,
  input  logic                      reset,
  dn_benes_cfg_ctrl_if.slave        cfg_if,
  output logic                      cfg_err,
  output logic                      route_en,
  output logic                      out_valid,
  output logic                      set_en,
  output logic [N_LEVELS*CFG_W-1:0] route_signals,
  output logic                      busy
);

  localparam int CNT_W = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1;
  localparam int INF_W = $clog2(NET_LAT+1);
  localparam logic [CNT_W-1:0] LAST_LVL = CNT_W'(N_LEVELS-1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [INF_W-1:0] INF_ONE  = INF_W'(1);

  typedef enum logic [1:0] {
    NOCFG = 2'd0,
    APPLY = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cfg_cnt_q, cfg_cnt_d;
  logic                      shadow_full_q, shadow_full_d;
  logic [N_LEVELS*CFG_W-1:0] shadow_q, shadow_d;
  logic [N_LEVELS*CFG_W-1:0] active_q, active_d;
  logic [NET_LAT-1:0]        lat_q, lat_d;
  logic [INF_W-1:0]          in_flight_q, in_flight_d;
  logic                      cfg_ready_q, cfg_ready_d;
  logic                      in_ready_q, in_ready_d;
  logic                      set_en_q, set_en_d;
  logic                      cfg_err_q, cfg_err_d;
  logic                      busy_q, busy_d;

  logic cfg_accept;
  logic at_last_lvl;
  logic frame_err;
  logic frame_done;

  assign cfg_accept  = cfg_if.cfg_valid && cfg_ready_q;
  assign at_last_lvl = (cfg_cnt_q == LAST_LVL);
  assign frame_err   = cfg_accept && (cfg_if.cfg_last != at_last_lvl);
  assign frame_done  = cfg_accept && cfg_if.cfg_last && at_last_lvl;

  assign cfg_if.cfg_ready = cfg_ready_q;
  assign cfg_if.in_ready  = in_ready_q;
  assign route_en         = cfg_if.in_valid && in_ready_q;
  assign out_valid        = lat_q[NET_LAT-1];
  assign set_en           = set_en_q;
  assign cfg_err          = cfg_err_q;
  assign route_signals    = active_q;
  assign busy             = busy_q;

  // Shadow bank fill: write one level per accepted word, restart on framing errors
  always_comb begin
    cfg_cnt_d     = cfg_cnt_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    cfg_err_d     = frame_err;
    if (cfg_accept) begin
      if (frame_err) begin
        cfg_cnt_d = '0;
      end else begin
        shadow_d[int'(cfg_cnt_q)*CFG_W +: CFG_W] = cfg_if.cfg_data;
        if (frame_done) begin
          shadow_full_d = 1'b1;
          cfg_cnt_d     = '0;
        end else begin
          cfg_cnt_d = cfg_cnt_q + CNT_ONE;
        end
      end
    end
    if (state_q == APPLY) begin
      shadow_full_d = 1'b0;
    end
  end

  // Data-path sequencing: hold data while a new config waits for the pipe to empty
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    unique case (state_q)
      NOCFG: if (shadow_full_q) state_d = APPLY;
      APPLY: begin
        active_d = shadow_q;
        state_d  = RUN;
      end
      RUN:   if (shadow_full_q) state_d = DRAIN;
      DRAIN: if (in_flight_q == '0) state_d = APPLY;
      default: state_d = NOCFG;
    endcase
  end

  // Latency tracking: beats march through a shift register, in_flight counts them
  always_comb begin
    lat_d       = (lat_q << 1) | NET_LAT'(route_en);
    in_flight_d = in_flight_q;
    if (route_en && !out_valid) begin
      in_flight_d = in_flight_q + INF_ONE;
    end else if (!route_en && out_valid) begin
      in_flight_d = in_flight_q - INF_ONE;
    end
  end

  // Registered outputs derived from next-state values so they line up with state
  always_comb begin
    cfg_ready_d = !shadow_full_d;
    in_ready_d  = (state_d == RUN) && !shadow_full_d;
    set_en_d    = (state_d == APPLY);
    busy_d      = (state_d != NOCFG) || (cfg_cnt_d != '0) || (in_flight_d != '0);
  end

  // All controller state, cleared asynchronously so partial work is discarded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= NOCFG;
      cfg_cnt_q     <= '0;
      shadow_full_q <= 1'b0;
      shadow_q      <= '0;
      active_q      <= '0;
      lat_q         <= '0;
      in_flight_q   <= '0;
      cfg_ready_q   <= 1'b1;
      in_ready_q    <= 1'b0;
      set_en_q      <= 1'b0;
      cfg_err_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cfg_cnt_q     <= cfg_cnt_d;
      shadow_full_q <= shadow_full_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      lat_q         <= lat_d;
      in_flight_q   <= in_flight_d;
      cfg_ready_q   <= cfg_ready_d;
      in_ready_q    <= in_ready_d;
      set_en_q      <= set_en_d;
      cfg_err_q     <= cfg_err_d;
      busy_q        <= busy_d;
    end
  end

endmodule

// File: tb/tb_dn_benes_cfg_ctrl.sv
// Directed bench for dn_benes_cfg_ctrl with N=8 (5 levels, latency 5).
// A cycle table covers first config load and a data burst; hand sequences
// cover drain-before-apply, stalled config, framing error and mid-run reset.
module tb_dn_benes_cfg_ctrl;

  localparam int N        = 8;
  localparam int N_LEVELS = 5;
  localparam int NET_LAT  = 5;
  localparam int CFG_W    = 8;
  localparam int RS_W     = N_LEVELS*CFG_W;
  localparam int N_VECS   = 21;

  logic clk = 1'b0;
  logic reset;
  logic cfg_err, route_en, out_valid, set_en, busy;
  logic [RS_W-1:0] route_signals;

  int tests_run    = 0;
  int tests_failed = 0;

  dn_benes_cfg_ctrl_if #(.CFG_W(CFG_W)) cfg_if ();

  dn_benes_cfg_ctrl #(
    .N(N), .N_LEVELS(N_LEVELS), .NET_LAT(NET_LAT), .CFG_W(CFG_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_if(cfg_if),
    .cfg_err(cfg_err),
    .route_en(route_en),
    .out_valid(out_valid),
    .set_en(set_en),
    .route_signals(route_signals),
    .busy(busy)
  );

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  // Guard against a stuck run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got still running, required finished");
    $fatal(1);
  end

  typedef struct {
    logic             cv;
    logic [CFG_W-1:0] cd;
    logic             cl;
    logic             iv;
    logic [6:0]       exp_out;
    logic [RS_W-1:0]  exp_rs;
  } vec_t;

  vec_t vecs [N_VECS];

  function automatic vec_t mk(logic cv, logic [CFG_W-1:0] cd, logic cl, logic iv,
                              logic [6:0] e, logic [RS_W-1:0] rs);
    vec_t v;
    v.cv = cv; v.cd = cd; v.cl = cl; v.iv = iv; v.exp_out = e; v.exp_rs = rs;
    return v;
  endfunction

  // {cfg_ready, in_ready, route_en, out_valid, set_en, cfg_err, busy}
  function automatic logic [6:0] outs();
    return {cfg_if.cfg_ready, cfg_if.in_ready, route_en, out_valid, set_en, cfg_err, busy};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cv, input logic [CFG_W-1:0] cd, input logic cl, input logic iv);
    cfg_if.cfg_valid = cv;
    cfg_if.cfg_data  = cd;
    cfg_if.cfg_last  = cl;
    cfg_if.in_valid  = iv;
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(v.cv, v.cd, v.cl, v.iv);
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [RS_W-1:0] CFG_A = 40'h5544332211;
  localparam logic [RS_W-1:0] CFG_B = 40'hA5A4A3A2A1;
  localparam logic [RS_W-1:0] CFG_C = 40'hC5C4C3C2C1;

  initial begin
    int max_inflight;
    int set_cnt;
    int set_at;
    int ov_cnt;
    int busy_cnt;

    // Cycle table: load CFG_A, apply, then an 8-beat burst
    vecs[0] = mk(1'b1, 8'h11, 1'b0, 1'b0, 7'b1000000, '0);
    vecs[1] = mk(1'b1, 8'h22, 1'b0, 1'b0, 7'b1000001, '0);
    vecs[2] = mk(1'b1, 8'h33, 1'b0, 1'b0, 7'b1000001, '0);
    vecs[3] = mk(1'b1, 8'h44, 1'b0, 1'b0, 7'b1000001, '0);
    vecs[4] = mk(1'b1, 8'h55, 1'b1, 1'b0, 7'b1000001, '0);
    vecs[5] = mk(1'b0, 8'h00, 1'b0, 1'b0, 7'b0000000, '0);
    vecs[6] = mk(1'b0, 8'h00, 1'b0, 1'b0, 7'b0000101, '0);
    for (int i = 7; i <= 11; i++)  vecs[i] = mk(1'b0, 8'h00, 1'b0, 1'b1, 7'b1110001, CFG_A);
    for (int i = 12; i <= 14; i++) vecs[i] = mk(1'b0, 8'h00, 1'b0, 1'b1, 7'b1111001, CFG_A);
    for (int i = 15; i <= 19; i++) vecs[i] = mk(1'b0, 8'h00, 1'b0, 1'b0, 7'b1101001, CFG_A);
    vecs[20] = mk(1'b0, 8'h00, 1'b0, 1'b0, 7'b1100001, CFG_A);

    // Reset state
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs", 64'(outs()), 64'(7'b1000000));
    checkOutput("reset_route_signals", 64'(route_signals), 64'(0));
    reset = 1'b1;

    // Table-driven first load and burst
    max_inflight = 0;
    for (int i = 0; i < N_VECS; i++) begin
      step();
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_outputs", i), 64'(outs()), 64'(vecs[i].exp_out));
      checkOutput($sformatf("vec%0d_route_signals", i), 64'(route_signals), 64'(vecs[i].exp_rs));
      if (int'(dut.in_flight_q) > max_inflight) max_inflight = int'(dut.in_flight_q);
    end
    checkOutput("burst_inflight_peak", 64'(max_inflight), 64'(5));
    checkOutput("burst_inflight_final", 64'(dut.in_flight_q), 64'(0));

    // New config CFG_B loaded while three beats enter the network
    for (int k = 0; k < 5; k++) begin
      step();
      drive(1'b1, 8'hA1 + 8'(k), (k == 4), (k >= 2));
      #1;
      checkOutput($sformatf("preload%0d_ready_route", k),
                  64'({cfg_if.cfg_ready, route_en}), 64'({1'b1, (k >= 2)}));
    end

    // Drain: data and a further config word are both held off until after APPLY
    for (int c = 0; c < 7; c++) begin
      step();
      drive(1'b1, 8'hB1, 1'b0, 1'b1);
      #1;
      checkOutput($sformatf("drain%0d_ready_route_ov_set", c),
                  64'({cfg_if.cfg_ready, route_en, out_valid, set_en}),
                  64'({1'b0, 1'b0, (c >= 2 && c <= 4), (c == 6)}));
      if (c == 6) checkOutput("apply_inflight_zero", 64'(dut.in_flight_q), 64'(0));
    end

    // First RUN cycle under CFG_B: stalled word accepted, data resumes
    step();
    drive(1'b1, 8'hB1, 1'b0, 1'b1);
    #1;
    checkOutput("after_apply_ready_route_set",
                64'({cfg_if.cfg_ready, cfg_if.in_ready, route_en, set_en}), 64'(4'b1110));
    checkOutput("after_apply_route_signals", 64'(route_signals), 64'(CFG_B));

    // Framing error: cfg_last on the third word
    step();
    drive(1'b1, 8'hB2, 1'b0, 1'b0);
    #1;
    checkOutput("frame_word2_err", 64'(cfg_err), 64'(0));
    step();
    drive(1'b1, 8'hB3, 1'b1, 1'b0);
    #1;
    checkOutput("frame_word3_err", 64'(cfg_err), 64'(0));
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    checkOutput("frame_err_pulse", 64'({cfg_err, set_en}), 64'(2'b10));

    // Correct CFG_C sequence after the error
    for (int k = 0; k < 5; k++) begin
      step();
      drive(1'b1, 8'hC1 + 8'(k), (k == 4), 1'b0);
      #1;
      checkOutput($sformatf("cfgC%0d_err_set", k), 64'({cfg_err, set_en}), 64'(2'b00));
      checkOutput($sformatf("cfgC%0d_route_signals", k), 64'(route_signals), 64'(CFG_B));
    end
    set_cnt = 0;
    set_at  = 0;
    for (int w = 1; w <= 10; w++) begin
      step();
      drive(1'b0, '0, 1'b0, 1'b0);
      #1;
      if (set_en) begin
        set_cnt++;
        set_at = w;
      end
    end
    checkOutput("cfgC_set_en_count", 64'(set_cnt), 64'(1));
    checkOutput("cfgC_set_en_delay", 64'(set_at), 64'(3));
    checkOutput("cfgC_route_signals", 64'(route_signals), 64'(CFG_C));

    // Reset with two beats in flight and two config words loaded
    for (int k = 0; k < 2; k++) begin
      step();
      drive(1'b1, 8'hD1 + 8'(k), 1'b0, 1'b1);
      #1;
      checkOutput($sformatf("prereset%0d_route_en", k), 64'(route_en), 64'(1));
    end
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("midreset_outputs", 64'(outs()), 64'(7'b1000000));
    checkOutput("midreset_route_signals", 64'(route_signals), 64'(0));
    repeat (2) step();
    reset = 1'b1;
    ov_cnt   = 0;
    busy_cnt = 0;
    for (int w = 0; w < 10; w++) begin
      step();
      #1;
      if (out_valid) ov_cnt++;
      if (busy) busy_cnt++;
    end
    checkOutput("postreset_out_valid_count", 64'(ov_cnt), 64'(0));
    checkOutput("postreset_busy_count", 64'(busy_cnt), 64'(0));
    step();
    drive(1'b0, '0, 1'b0, 1'b1);
    #1;
    checkOutput("postreset_nocfg_blocks_data",
                64'({cfg_if.cfg_ready, cfg_if.in_ready, route_en}), 64'(3'b100));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
